// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with N read ports, write bypass and busy scoreboard
//
// Purpose: decode-stage register file. Register 0 is hardwired to zero. Each
// non-zero register carries a busy bit that is set when an instruction with
// that destination issues and is cleared when the producing write lands. The
// hazard unit uses the per-port busy outputs to stall operand reads.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-high reset
//   ra       - packed read addresses, port p at [p*BANK_WIDTH +: BANK_WIDTH]
//   rd       - packed read data, port p at [p*WIDTH +: WIDTH]
//   rd_busy  - per-port: operand still has an in-flight producer
//   we3/wa3/wd3 - write enable / address / data
//   bs_en/bs_addr - mark destination register busy
//   any_busy - OR of all stored busy bits
//   waw_err  - sticky: busy-set hit an already-busy register

module regfile_sb #(
    parameter int BANK_WIDTH = 5,
    parameter int WIDTH      = 64,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*BANK_WIDTH-1:0] ra,
    output logic [READ_PORTS*WIDTH-1:0]      rd,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             we3,
    input  logic [BANK_WIDTH-1:0]            wa3,
    input  logic [WIDTH-1:0]                 wd3,
    input  logic                             bs_en,
    input  logic [BANK_WIDTH-1:0]            bs_addr,
    output logic                             any_busy,
    output logic                             waw_err
);

    localparam int WORDS = 1 << BANK_WIDTH;

    logic [WIDTH-1:0] ram_q [WORDS];
    logic [WORDS-1:0] busy_q, busy_d;
    logic             waw_err_q, waw_err_d;

    // Writes and busy-sets targeting register 0 are dropped everywhere.
    logic wr_ok;
    logic bs_ok;
    assign wr_ok = we3 && (wa3 != '0);
    assign bs_ok = bs_en && (bs_addr != '0);

    // Clear from the landing write first, then set: when both hit the same
    // register the newly issued producer wins and the bit stays set.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wa3] = 1'b0;
        end
        if (bs_ok) begin
            busy_d[bs_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // A same-cycle write to the destination retires the old producer, so
    // re-issuing to it is not a write-after-write conflict.
    always_comb begin
        waw_err_d = waw_err_q;
        if (bs_ok && busy_q[bs_addr] && !(we3 && (wa3 == bs_addr))) begin
            waw_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                ram_q[i] <= (INIT_INDEX != 0) ? WIDTH'(i) : '0;
            end
            busy_q    <= '0;
            waw_err_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                ram_q[wa3] <= wd3;
            end
            busy_q    <= busy_d;
            waw_err_q <= waw_err_d;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rport
        logic [BANK_WIDTH-1:0] addr;
        logic                  fwd;
        assign addr = ra[p*BANK_WIDTH +: BANK_WIDTH];
        assign fwd  = (BYPASS != 0) && wr_ok && (wa3 == addr);

        always_comb begin
            if (addr == '0) begin
                rd[p*WIDTH +: WIDTH] = '0;
            end else if (fwd) begin
                rd[p*WIDTH +: WIDTH] = wd3;
            end else begin
                rd[p*WIDTH +: WIDTH] = ram_q[addr];
            end
        end

        // A forwarded write satisfies the operand this cycle, so it is not busy.
        assign rd_busy[p] = busy_q[addr] && !fwd && (addr != '0);
    end

    assign any_busy = |busy_q;
    assign waw_err  = waw_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (bypass 4-port and non-bypass 2-port instances)

module tb_regfile_sb;

    localparam int BW = 5;
    localparam int W  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*BW-1:0] ra;
    logic [4*W-1:0]  rd_b;
    logic [2*W-1:0]  rd_n;
    logic [3:0]      rdb_b;
    logic [1:0]      rdb_n;
    logic            we3;
    logic [BW-1:0]   wa3;
    logic [W-1:0]    wd3;
    logic            bs_en;
    logic [BW-1:0]   bs_addr;
    logic            any_b, any_n, waw_b, waw_n;

    always #5 clk = ~clk;

    regfile_sb #(.BANK_WIDTH(BW), .WIDTH(W), .READ_PORTS(4), .BYPASS(1), .INIT_INDEX(1)) u_byp (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rd_busy(rdb_b),
        .we3(we3), .wa3(wa3), .wd3(wd3), .bs_en(bs_en), .bs_addr(bs_addr),
        .any_busy(any_b), .waw_err(waw_b)
    );

    regfile_sb #(.BANK_WIDTH(BW), .WIDTH(W), .READ_PORTS(2), .BYPASS(0), .INIT_INDEX(1)) u_nob (
        .clk(clk), .reset(reset), .ra(ra[2*BW-1:0]), .rd(rd_n), .rd_busy(rdb_n),
        .we3(we3), .wa3(wa3), .wd3(wd3), .bs_en(bs_en), .bs_addr(bs_addr),
        .any_busy(any_n), .waw_err(waw_n)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) passed++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [63:0] rdb(input int p);
        return rd_b[p*W +: W];
    endfunction

    function automatic logic [63:0] rdn(input int p);
        return rd_n[p*W +: W];
    endfunction

    task automatic set_ra(input int p, input logic [BW-1:0] a);
        ra[p*BW +: BW] = a;
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ra = '0; we3 = 1'b0; wa3 = '0; wd3 = '0; bs_en = 1'b0; bs_addr = '0;

        // Reset state, INIT_INDEX=1
        set_ra(0, 5'd7); set_ra(1, 5'd31);
        #2;
        push("rst_b_rd0_r7", 64'd7);   chk(rdb(0));
        push("rst_b_rd1_r31", 64'd31); chk(rdb(1));
        push("rst_n_rd0_r7", 64'd7);   chk(rdn(0));
        push("rst_n_rd1_r31", 64'd31); chk(rdn(1));
        set_ra(0, 5'd0);
        #1;
        push("rst_rd0_r0", 64'd0);     chk(rdb(0));
        push("rst_any_busy", 64'd0);   chk({63'd0, any_b});
        push("rst_waw", 64'd0);        chk({63'd0, waw_b});
        #3 reset = 1'b0;
        edge_then_settle();

        // Write reg 5 with bypass vs. without
        we3 = 1'b1; wa3 = 5'd5; wd3 = 64'hDEAD_BEEF; set_ra(0, 5'd5);
        #1;
        push("byp_same_cycle", 64'hDEAD_BEEF); chk(rdb(0));
        push("nob_same_cycle", 64'd5);         chk(rdn(0));
        edge_then_settle();
        we3 = 1'b0;
        #1;
        push("byp_next_cycle", 64'hDEAD_BEEF); chk(rdb(0));
        push("nob_next_cycle", 64'hDEAD_BEEF); chk(rdn(0));

        // Register 0 writes and busy-sets are ignored
        we3 = 1'b1; wa3 = 5'd0; wd3 = 64'h1234; bs_en = 1'b1; bs_addr = 5'd0; set_ra(0, 5'd0);
        #1;
        push("r0_bypass_read", 64'd0); chk(rdb(0));
        push("r0_rd_busy", 64'd0);     chk({63'd0, rdb_b[0]});
        edge_then_settle();
        we3 = 1'b0; bs_en = 1'b0;
        #1;
        push("r0_after_write", 64'd0); chk(rdb(0));
        push("r0_rd_busy_after", 64'd0); chk({63'd0, rdb_b[0]});
        push("r0_waw", 64'd0);         chk({63'd0, waw_b});
        push("r0_any_busy", 64'd0);    chk({63'd0, any_b});

        // Busy set on 9, then cleared by the write
        bs_en = 1'b1; bs_addr = 5'd9;
        edge_then_settle();
        bs_en = 1'b0; set_ra(1, 5'd9);
        #1;
        push("r9_rd_busy_b", 64'd1);   chk({63'd0, rdb_b[1]});
        push("r9_rd_busy_n", 64'd1);   chk({63'd0, rdb_n[1]});
        push("r9_any_busy", 64'd1);    chk({63'd0, any_b});
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'h99;
        #1;
        push("r9_clr_byp", 64'd0);     chk({63'd0, rdb_b[1]});
        push("r9_clr_nob", 64'd1);     chk({63'd0, rdb_n[1]});
        push("r9_any_still", 64'd1);   chk({63'd0, any_b});
        edge_then_settle();
        we3 = 1'b0;
        #1;
        push("r9_after_b", 64'd0);     chk({63'd0, rdb_b[1]});
        push("r9_after_n", 64'd0);     chk({63'd0, rdb_n[1]});
        push("r9_any_b_after", 64'd0); chk({63'd0, any_b});
        push("r9_any_n_after", 64'd0); chk({63'd0, any_n});
        push("r9_data", 64'h99);       chk(rdn(1));

        // Write to a non-busy register: no error, stays clear
        we3 = 1'b1; wa3 = 5'd20; wd3 = 64'h20;
        edge_then_settle();
        we3 = 1'b0; set_ra(0, 5'd20);
        #1;
        push("nonbusy_wr_busy", 64'd0); chk({63'd0, rdb_b[0]});
        push("nonbusy_wr_waw", 64'd0);  chk({63'd0, waw_b});

        // Busy 12, then set+write same cycle (no WAW), then set again (WAW)
        bs_en = 1'b1; bs_addr = 5'd12;
        edge_then_settle();
        we3 = 1'b1; wa3 = 5'd12; wd3 = 64'hC;
        edge_then_settle();
        we3 = 1'b0; bs_en = 1'b0; set_ra(0, 5'd12);
        #1;
        push("r12_set_wr_busy", 64'd1); chk({63'd0, rdb_b[0]});
        push("r12_set_wr_waw_b", 64'd0); chk({63'd0, waw_b});
        push("r12_set_wr_waw_n", 64'd0); chk({63'd0, waw_n});
        bs_en = 1'b1; bs_addr = 5'd12;
        edge_then_settle();
        bs_en = 1'b0;
        #1;
        push("r12_waw_b", 64'd1);      chk({63'd0, waw_b});
        push("r12_waw_n", 64'd1);      chk({63'd0, waw_n});
        push("r12_still_busy", 64'd1); chk({63'd0, rdb_b[0]});
        edge_then_settle();
        edge_then_settle();
        push("r12_waw_sticky", 64'd1); chk({63'd0, waw_b});

        // Four ports on reg 3, then asynchronous reset between edges
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hAA;
        edge_then_settle();
        we3 = 1'b0;
        for (int p = 0; p < 4; p++) set_ra(p, 5'd3);
        #1;
        for (int p = 0; p < 4; p++) begin
            push($sformatf("p%0d_rd_r3", p), 64'hAA);
            chk(rdb(p));
        end
        push("pre_rst_any_busy", 64'd1); chk({63'd0, any_b});
        reset = 1'b1;
        #1;
        for (int p = 0; p < 4; p++) begin
            push($sformatf("p%0d_rd_async_rst", p), 64'd3);
            chk(rdb(p));
        end
        push("async_rst_waw", 64'd0);  chk({63'd0, waw_b});
        push("async_rst_any", 64'd0);  chk({63'd0, any_b});
        set_ra(0, 5'd12);
        #1;
        push("async_rst_r12_busy", 64'd0); chk({63'd0, rdb_b[0]});
        push("async_rst_r12_data", 64'd12); chk(rdb(0));

        // Pending write/set while reset is still high at the edge is dropped
        we3 = 1'b1; wa3 = 5'd12; wd3 = 64'hFF; bs_en = 1'b1; bs_addr = 5'd12;
        edge_then_settle();
        we3 = 1'b0; bs_en = 1'b0; reset = 1'b0;
        #1;
        push("rst_edge_data", 64'd12); chk(rdb(0));
        push("rst_edge_busy", 64'd0);  chk({63'd0, any_b});

        if (sb_q.size() != 0) begin
            total++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
